// File: rtl/pcie_dest_drain.sv
// Egress drain for the D0/D1 destination FIFOs: pops, captures and buffers words for two valid/ready sinks.
// Optional delivered-word counters are built when DEST_DRAIN_CNT_EN is defined.
module pcie_dest_drain #(
    parameter int DATA_W    = 6,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic              fifo_empty0,
    input  logic              fifo_empty1,
    input  logic [DATA_W-1:0] fifo_data0,
    input  logic [DATA_W-1:0] fifo_data1,
    input  logic              ready0,
    input  logic              ready1,
    output logic              pop0,
    output logic              pop1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic [CNT_W-1:0]  count0,
    output logic [CNT_W-1:0]  count1
);
    localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
    // One bit wider than the occupancy needs so occ + inflight never wraps.
    localparam int OCC_W = $clog2(BUF_DEPTH + 1) + 1;

    typedef enum logic {DRAIN, HOLD} mode_t;
    mode_t state_reg, state_next;
    logic  hold;

    logic [1:0]        empty_v, ready_v, pop_v, valid_v;
    logic [DATA_W-1:0] fdata_v [2];
    logic [DATA_W-1:0] data_v  [2];
    logic [CNT_W-1:0]  count_v [2];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state_reg <= DRAIN;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DRAIN:   if (init)  state_next = HOLD;
            HOLD:    if (!init) state_next = DRAIN;
            default: state_next = DRAIN;
        endcase
    end

    // init blocks pops in its own cycle; HOLD extends that by one cycle after init falls.
    assign hold = init | (state_reg == HOLD);

    assign empty_v    = {fifo_empty1, fifo_empty0};
    assign ready_v    = {ready1, ready0};
    assign fdata_v[0] = fifo_data0;
    assign fdata_v[1] = fifo_data1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dest
            logic [OCC_W-1:0]  occ_reg, occ_next;
            logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg, rd_ptr_next, wr_ptr_next;
            logic              inflight_reg;
            logic [DATA_W-1:0] data_out_reg, head_next;
            logic [DATA_W-1:0] mem [BUF_DEPTH];
            logic              deq;

            assign deq      = (occ_reg != '0) & ready_v[gi];
            assign occ_next = occ_reg + OCC_W'(inflight_reg) - OCC_W'(deq);
            assign pop_v[gi] = reset_L & ~empty_v[gi] & ~hold & (occ_next < OCC_W'(BUF_DEPTH));

            always_comb begin
                rd_ptr_next = deq ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
                wr_ptr_next = inflight_reg ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
                head_next   = data_out_reg;
                // Arriving word goes straight to the head when nothing else is left behind it.
                if (occ_next != '0) begin
                    if (inflight_reg && ((occ_reg - OCC_W'(deq)) == '0))
                        head_next = fdata_v[gi];
                    else
                        head_next = mem[rd_ptr_next];
                end
            end

            always_ff @(posedge clk) begin
                if (inflight_reg) mem[wr_ptr_reg] <= fdata_v[gi];
            end

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    occ_reg      <= '0;
                    rd_ptr_reg   <= '0;
                    wr_ptr_reg   <= '0;
                    inflight_reg <= 1'b0;
                    data_out_reg <= '0;
                end else begin
                    occ_reg      <= occ_next;
                    rd_ptr_reg   <= rd_ptr_next;
                    wr_ptr_reg   <= wr_ptr_next;
                    inflight_reg <= pop_v[gi];
                    data_out_reg <= head_next;
                end
            end

            assign valid_v[gi] = (occ_reg != '0);
            assign data_v[gi]  = data_out_reg;

`ifdef DEST_DRAIN_CNT_EN
            logic [CNT_W-1:0] count_reg;
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L)                     count_reg <= '0;
                else if (hold)                    count_reg <= '0;
                else if (deq && count_reg != '1)  count_reg <= count_reg + CNT_W'(1);
            end
            assign count_v[gi] = count_reg;
`else
            assign count_v[gi] = '0;
`endif
        end
    endgenerate

    assign pop0       = pop_v[0];
    assign pop1       = pop_v[1];
    assign valid_out0 = valid_v[0];
    assign valid_out1 = valid_v[1];
    assign data_out0  = data_v[0];
    assign data_out1  = data_v[1];
    assign count0     = count_v[0];
    assign count1     = count_v[1];
endmodule

// File: tb/tb_pcie_dest_drain.sv
// Bench for pcie_dest_drain: queue-based behavioural model checked every cycle, plus directed literal checks.
module tb_pcie_dest_drain;
    localparam int DATA_W    = 6;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 4;
`ifdef DEST_DRAIN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_L = 1'b0;
    logic              init = 1'b0;
    logic              fifo_empty0 = 1'b1, fifo_empty1 = 1'b1;
    logic [DATA_W-1:0] fdata [2];
    logic              ready0 = 1'b0, ready1 = 1'b0;
    logic              pop0, pop1, valid_out0, valid_out1;
    logic [DATA_W-1:0] data_out0, data_out1;
    logic [CNT_W-1:0]  count0, count1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] src_q [2][$];
    logic [DATA_W-1:0] exp_q [2][$];
    logic [DATA_W-1:0] m_buf [2][$];
    int                pop_log [2][$];
    logic [DATA_W-1:0] dlv_w [2][$];
    int                dlv_c [2][$];
    logic [1:0]        pop_s = 2'b00;

    logic [DATA_W-1:0] m_last [2];
    bit                m_infl [2];
    int                m_cnt  [2];
    bit                m_hold;

    pcie_dest_drain #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1),
        .fifo_data0(fdata[0]), .fifo_data1(fdata[1]),
        .ready0(ready0), .ready1(ready1),
        .pop0(pop0), .pop1(pop1),
        .data_out0(data_out0), .data_out1(data_out1),
        .valid_out0(valid_out0), .valid_out1(valid_out1),
        .count0(count0), .count1(count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dest%0d cycle %0d: got %0h, expected %0h", name, d, cyc, act, exp);
        end
    endtask

    // Model of the surrounding world and of the block, evaluated mid-cycle when everything is stable.
    always @(negedge clk) begin : mon
        logic [1:0]        d_pop, d_val, rdy, emp;
        logic [DATA_W-1:0] d_dat [2];
        logic [DATA_W-1:0] fd [2];
        logic [CNT_W-1:0]  d_cnt [2];
        logic [DATA_W-1:0] e_data, w;
        bit                hold, e_valid, deq, e_pop;
        int                occ_after, e_cnt;
        cyc++;
        d_pop = {pop1, pop0};
        d_val = {valid_out1, valid_out0};
        rdy   = {ready1, ready0};
        emp   = {fifo_empty1, fifo_empty0};
        d_dat[0] = data_out0; d_dat[1] = data_out1;
        d_cnt[0] = count0;    d_cnt[1] = count1;
        fd[0] = fdata[0];     fd[1] = fdata[1];
        pop_s = d_pop;
        if (!reset_L) begin
            for (int d = 0; d < 2; d++) begin
                chk("rst_pop", d, 32'(d_pop[d]), 0);
                chk("rst_valid", d, 32'(d_val[d]), 0);
                chk("rst_data", d, 32'(d_dat[d]), 0);
                chk("rst_count", d, 32'(d_cnt[d]), 0);
                m_buf[d].delete();
                m_last[d] = '0;
                m_infl[d] = 1'b0;
                m_cnt[d]  = 0;
            end
            m_hold = 1'b0;
        end else begin
            hold = init | m_hold;
            for (int d = 0; d < 2; d++) begin
                e_valid   = (m_buf[d].size() != 0);
                e_data    = e_valid ? m_buf[d][0] : m_last[d];
                deq       = e_valid && rdy[d];
                occ_after = m_buf[d].size() + int'(m_infl[d]) - int'(deq);
                e_pop     = !emp[d] && !hold && (occ_after < BUF_DEPTH);
                e_cnt     = CNT_EN ? m_cnt[d] : 0;
                chk("pop", d, 32'(d_pop[d]), 32'(e_pop));
                chk("valid", d, 32'(d_val[d]), 32'(e_valid));
                chk("data", d, 32'(d_dat[d]), 32'(e_data));
                chk("count", d, 32'(d_cnt[d]), 32'(e_cnt));
                if (d_pop[d]) pop_log[d].push_back(cyc);
                if (deq) begin
                    w = m_buf[d].pop_front();
                    m_last[d] = w;
                    dlv_w[d].push_back(w);
                    dlv_c[d].push_back(cyc);
                    $display("dest%0d delivered %0h at cycle %0d", d, w, cyc);
                    if (exp_q[d].size() != 0) chk("order", d, 32'(w), 32'(exp_q[d].pop_front()));
                    else chk("unexpected_word", d, 32'(w), 32'hFFFF_FFFF);
                end
                if (hold) m_cnt[d] = 0;
                else if (deq && m_cnt[d] < CNT_MAX) m_cnt[d]++;
                if (m_infl[d]) m_buf[d].push_back(fd[d]);
                m_infl[d] = e_pop;
            end
            m_hold = init;
        end
    end

    task automatic refresh_empty();
        fifo_empty0 = (src_q[0].size() == 0);
        fifo_empty1 = (src_q[1].size() == 0);
    endtask

    // One clock: the FIFO model answers the previous cycle's pops one cycle later.
    task automatic tick();
        logic rst_edge;
        @(posedge clk);
        rst_edge = reset_L;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (pop_s[d] && rst_edge) begin
                chk("no_underflow", d, 32'(src_q[d].size() != 0), 1);
                if (src_q[d].size() != 0) fdata[d] = src_q[d].pop_front();
            end
        end
        refresh_empty();
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input int d, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            src_q[d].push_back(DATA_W'(base + i));
            exp_q[d].push_back(DATA_W'(base + i));
        end
        refresh_empty();
    endtask

    task automatic start_test();
        tick();
        reset_L = 1'b0;
        init = 1'b0;
        ready0 = 1'b0;
        ready1 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            src_q[d].delete(); exp_q[d].delete();
            pop_log[d].delete(); dlv_w[d].delete(); dlv_c[d].delete();
        end
        refresh_empty();
        tickn(2);
    endtask

    initial begin
        int rel, iw_start, iw_end, n_in;
        fdata[0] = '0;
        fdata[1] = '0;

        // Reset release, latency and 4-word stream.
        start_test();
        load(0, 'h11, 4);
        ready0 = 1'b1;
        tickn(2);
        reset_L = 1'b1;
        rel = cyc + 1;
        tickn(10);
        chk("t1_first_pop", 0, 32'(pop_log[0].size() != 0 ? pop_log[0][0] : -1), 32'(rel));
        chk("t2_pop_count", 0, 32'(pop_log[0].size()), 4);
        chk("t2_pop_last", 0, 32'(pop_log[0].size() == 4 ? pop_log[0][3] : -1), 32'(rel + 3));
        chk("t2_dlv_count", 0, 32'(dlv_w[0].size()), 4);
        for (int i = 0; i < dlv_w[0].size() && i < 4; i++) begin
            chk("t2_word", 0, 32'(dlv_w[0][i]), 32'('h11 + i));
            chk("t2_cycle", 0, 32'(dlv_c[0][i]), 32'(rel + 2 + i));
        end
        #2;
        chk("t2_count", 0, 32'(count0), CNT_EN ? 4 : 0);

        // Backpressure with 5 words.
        start_test();
        load(0, 'h01, 5);
        reset_L = 1'b1;
        tickn(6);
        chk("t3_pops_stalled", 0, 32'(pop_log[0].size()), 2);
        chk("t3_valid", 0, 32'(valid_out0), 1);
        chk("t3_data_steady", 0, 32'(data_out0), 'h01);
        ready0 = 1'b1;
        tickn(10);
        chk("t3_dlv_count", 0, 32'(dlv_w[0].size()), 5);
        for (int i = 1; i < dlv_c[0].size(); i++)
            chk("t3_gap", 0, 32'((dlv_c[0][i] - dlv_c[0][i-1]) <= 2), 1);
        chk("t3_all_out", 0, 32'(exp_q[0].size()), 0);

        // Both destinations streaming, sink 1 toggling.
        start_test();
        load(0, 'h20, 8);
        load(1, 'h30, 8);
        reset_L = 1'b1;
        ready0 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ready1 = (i % 2 == 0);
            tick();
        end
        chk("t4_dlv0", 0, 32'(dlv_w[0].size()), 8);
        chk("t4_dlv1", 1, 32'(dlv_w[1].size()), 8);
        for (int i = 1; i < dlv_c[0].size(); i++)
            chk("t4_d0_back_to_back", 0, 32'(dlv_c[0][i] - dlv_c[0][i-1]), 1);
        for (int i = 0; i < dlv_w[1].size() && i < 8; i++)
            chk("t4_d1_word", 1, 32'(dlv_w[1][i]), 32'('h30 + i));

        // init pulse mid-stream.
        start_test();
        load(0, 'h08, 10);
        reset_L = 1'b1;
        ready0 = 1'b1;
        tickn(4);
        init = 1'b1;
        iw_start = cyc + 1;
        tickn(3);
        init = 1'b0;
        iw_end = iw_start + 2;
        #2;
        chk("t5_count_after_init", 0, 32'(count0), 0);
        tickn(14);
        foreach (pop_log[0][i])
            if (pop_log[0][i] >= iw_start && pop_log[0][i] <= iw_end)
                chk("t5_pop_in_init", 0, 32'(pop_log[0][i]), 0);
        n_in = 0;
        foreach (dlv_c[0][i]) if (dlv_c[0][i] >= iw_start && dlv_c[0][i] <= iw_end) n_in++;
        chk("t5_drain_in_init", 0, 32'(n_in >= 1), 1);
        chk("t5_all_out", 0, 32'(exp_q[0].size()), 0);

        // Saturation and asynchronous reset mid-transfer.
        start_test();
        load(0, 'h01, 20);
        reset_L = 1'b1;
        ready0 = 1'b1;
        tickn(26);
        chk("t6_dlv_count", 0, 32'(dlv_w[0].size()), 20);
        #2;
        chk("t6_count_sat", 0, 32'(count0), CNT_EN ? 15 : 0);
        load(0, 'h30, 6);
        load(1, 'h38, 6);
        ready1 = 1'b1;
        tickn(4);
        #6;
        reset_L = 1'b0;
        #1;
        chk("t6_async_pop", 0, 32'(pop0), 0);
        chk("t6_async_pop", 1, 32'(pop1), 0);
        chk("t6_async_valid", 0, 32'(valid_out0), 0);
        chk("t6_async_valid", 1, 32'(valid_out1), 0);
        chk("t6_async_data", 0, 32'(data_out0), 0);
        chk("t6_async_data", 1, 32'(data_out1), 0);
        chk("t6_async_count", 0, 32'(count0), 0);
        chk("t6_async_count", 1, 32'(count1), 0);
        start_test();
        reset_L = 1'b1;
        tickn(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
